// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: latches the cipher key, derives one round key per
// clock into an 11-entry schedule buffer, and serves any round key combinationally by index.

module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Forward FIPS-197 S-box. Entry 0 is the most significant byte, so a byte value x sits at index ~x.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX_TABLE[~in_i];
endmodule

module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         KS_START,
  input  logic [127:0] KS_KEY,
  input  logic [3:0]   RK_INDEX,
  output logic [127:0] RK_OUT,
  output logic         KS_BUSY,
  output logic         KS_READY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] rk_q [0:NUM_ROUNDS];
  logic [127:0] rk_d [0:NUM_ROUNDS];
  logic [3:0]   round_q, round_d;
  logic         load_key, do_expand;

  logic [127:0] prev_rk, next_rk;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [7:0]   rcon;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (KS_START) state_d = S_EXPAND;
      S_EXPAND: if (round_q == 4'(NUM_ROUNDS)) state_d = S_READY;
      S_READY:  if (KS_START) state_d = S_EXPAND;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    KS_BUSY   = (state_q == S_EXPAND);
    KS_READY  = (state_q == S_READY);
    load_key  = KS_START && ((state_q == S_IDLE) || (state_q == S_READY));
    do_expand = (state_q == S_EXPAND);
  end

  // ---------------- Round function ----------------
  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (round_q == 4'(i + 1)) prev_rk = rk_q[i];
  end

  assign rot_w = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .in_i  (rot_w[8*g +: 8]),
      .out_o (sub_w[8*g +: 8])
    );
  end

  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w     = sub_w ^ {rcon, 24'h0};
  assign w0_n    = prev_rk[127:96] ^ t_w;
  assign w1_n    = prev_rk[95:64]  ^ w0_n;
  assign w2_n    = prev_rk[63:32]  ^ w1_n;
  assign w3_n    = prev_rk[31:0]   ^ w2_n;
  assign next_rk = {w0_n, w1_n, w2_n, w3_n};

  // ---------------- Schedule buffer ----------------
  always_comb begin
    rk_d    = rk_q;
    round_d = round_q;
    if (load_key) begin
      rk_d[0] = KS_KEY;
      round_d = 4'd1;
    end else if (do_expand) begin
      for (int i = 1; i <= NUM_ROUNDS; i++)
        if (round_q == 4'(i)) rk_d[i] = next_rk;
      round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
      round_q <= '0;
    end else begin
      rk_q    <= rk_d;
      round_q <= round_d;
    end
  end

  // Indices past the last round key read as zero.
  always_comb begin
    RK_OUT = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (RK_INDEX == 4'(i)) RK_OUT = rk_q[i];
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: random and known keys, expected round keys queued from a
// GF(2^8)-arithmetic reference model, and a monitor that sweeps the buffer on each READY.

module tb_aes_key_schedule;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         KS_START = 1'b0;
  logic [127:0] KS_KEY = '0;
  logic [3:0]   RK_INDEX = '0;
  logic [127:0] RK_OUT;
  logic         KS_BUSY;
  logic         KS_READY;

  int n_checks = 0;
  int n_pass = 0;
  logic [127:0] exp_q[$];
  bit sweep_req = 1'b0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .KS_START (KS_START),
    .KS_KEY   (KS_KEY),
    .RK_INDEX (RK_INDEX),
    .RK_OUT   (RK_OUT),
    .KS_BUSY  (KS_BUSY),
    .KS_READY (KS_READY)
  );

  // ---------------- clock ----------------
  always #20 CLK = ~CLK;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse followed by the affine transform.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = '0;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic push_expected(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    for (int r = 11; r < 16; r++) exp_q.push_back('0);
  endtask

  task automatic push_zeros();
    for (int r = 0; r < 16; r++) exp_q.push_back('0);
  endtask

  // ---------------- monitor ----------------
  task automatic do_sweep();
    for (int i = 0; i < 16; i++) begin
      RK_INDEX = 4'(i);
      #1;
      if (exp_q.size() == 0) check("rk_queue_empty", 128'(exp_q.size()), 128'd1);
      else check($sformatf("rk_out[%0d]", i), RK_OUT, exp_q.pop_front());
    end
  endtask

  initial begin
    bit ready_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET) check("busy_ready_exclusive", {127'b0, KS_BUSY & KS_READY}, '0);
      if ((KS_READY && !ready_prev) || sweep_req) begin
        sweep_req = 1'b0;
        do_sweep();
      end
      ready_prev = KS_READY;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_key(input logic [127:0] key, input bit disturb);
    int edges = 0;
    int busy_cnt = 0;
    bit got = 1'b0;
    KS_KEY   = key;
    KS_START = 1'b1;
    push_expected(key);
    @(posedge CLK); #1;
    KS_START = 1'b0;
    edges = 1;
    if (KS_BUSY) busy_cnt++;
    while (edges < 20 && !got) begin
      if (disturb && edges == 3) begin
        KS_START = 1'b1;
        KS_KEY   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge CLK); #1;
      edges++;
      if (disturb && edges == 4) KS_START = 1'b0;
      if (KS_READY) got = 1'b1;
      else if (KS_BUSY) busy_cnt++;
    end
    check("ready_latency_edges", 128'(edges), 128'd11);
    check("busy_cycles", 128'(busy_cnt), 128'd10);
  endtask

  task automatic run_reset_mid(input logic [127:0] key);
    KS_KEY   = key;
    KS_START = 1'b1;
    push_expected(key);
    @(posedge CLK); #1;
    KS_START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("reset_busy", {127'b0, KS_BUSY}, '0);
    check("reset_ready", {127'b0, KS_READY}, '0);
    exp_q.delete();
    push_zeros();
    sweep_req = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic run_hold(input logic [127:0] key);
    int cyc = 0;
    int pulses = 0;
    int last = 0;
    KS_KEY   = key;
    KS_START = 1'b1;
    for (int k = 0; k < 3; k++) push_expected(key);
    while (cyc < 60 && pulses < 3) begin
      @(posedge CLK); #1;
      cyc++;
      if (KS_READY) begin
        pulses++;
        if (pulses == 1) check("hold_first_ready", 128'(cyc), 128'd11);
        else check("hold_ready_period", 128'(cyc - last), 128'd11);
        last = cyc;
        if (pulses == 3) KS_START = 1'b0;
      end
    end
    KS_START = 1'b0;
    check("hold_pulse_count", 128'(pulses), 128'd3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("init_busy", {127'b0, KS_BUSY}, '0);
    check("init_ready", {127'b0, KS_READY}, '0);
    push_zeros();
    sweep_req = 1'b1;
    @(posedge CLK); #1;

    run_key(FIPS_KEY, 1'b0);
    run_key('0, 1'b0);
    run_key(FIPS_KEY, 1'b1);
    run_reset_mid({$urandom, $urandom, $urandom, $urandom});
    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int k = 0; k < 4; k++)
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    run_hold({$urandom, $urandom, $urandom, $urandom});

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 128'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    n_checks++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
